wb_flash_arbiter: RTL and testbench
===================================

# wb_flash_arbiter

Two-master Wishbone arbiter sharing the single SPI flash Wishbone slave (`wb_spi_flash_ctrl`) between the SD-card emulator core (master 0) and a maintenance/flash-loader port (master 1). It sits between `sd_top`'s Wishbone master and `wb_spi_flash_ctrl` in `sd_emu_top`, clocked from the Wishbone clock. It grants round-robin per bus cycle, locks the grant for the whole `cyc` assertion, and aborts hung transfers with a Wishbone error after a programmable timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 4096: cycles of `stb` without `ack` before abort; legal range 2..65535.
- `ADR_WIDTH`, default 32: address width.
- `DAT_WIDTH`, default 32: data width.

Ports:
- `wb_clk_i` in 1: Wishbone clock; single clock domain.
- `reset_n` in 1: asynchronous active-low reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: master 0 (SD core) control.
- `m0_adr_i` in ADR_WIDTH; `m0_dat_i` in DAT_WIDTH: master 0 address and write data.
- `m0_dat_o` out DAT_WIDTH: read data.
- `m0_ack_o` out 1; `m0_err_o` out 1: master 0 responses.
- `m1_*`: identical set for master 1 (loader).
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: to the flash slave.
- `s_adr_o` out ADR_WIDTH; `s_dat_o` out DAT_WIDTH: to the flash slave.
- `s_dat_i` in DAT_WIDTH; `s_ack_i` in 1: from the flash slave.
- `o_grant` out 2: one-hot owner, `00` when idle.
- `o_timeout` out 1: one-cycle pulse on abort.

## Operation

The FSM has three states: IDLE, OWNED and ABORT. A registered `owner` bit selects the master; a registered `last` bit drives round-robin.

**IDLE**
- All `s_*` control outputs are 0.
- If exactly one `mX_cyc_i` is high, that master becomes owner.
- If both are high, the master not equal to `last` becomes owner.
- Go to OWNED and set `last` to the new owner.

**OWNED**
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o` and `s_dat_o` are driven combinationally from the owner.
- `s_ack_i` is routed to the owner's `ack` only. The non-owner's `ack` and `err` stay 0.
- `s_dat_i` is fanned out to both `mX_dat_o`.
- When the owner's `cyc` goes low, go to IDLE.
- Timeout counter:
  - Increments each cycle the owner's `stb` is high and `s_ack_i` is low.
  - Clears on `s_ack_i` or when `stb` is low.
  - When it reaches `TIMEOUT_CYCLES-1` with no ack that cycle: pulse the owner's `err` and `o_timeout` for one cycle, then go to ABORT.

**ABORT**
- `s_cyc_o` and `s_stb_o` are forced to 0.
- `s_ack_i` is discarded.
- Stay in ABORT until the owner's `cyc` goes low, then go to IDLE.

Counter width is `$clog2(TIMEOUT_CYCLES)`. It saturates and never wraps.

## Timing

- **Reset:** all outputs are 0, state is IDLE, `owner`=0, `last`=1 (so master 0 wins the first tie), counter is 0. Reset is asynchronous and takes effect mid-transfer; a pending ack is lost.
- **Grant latency:** `cyc` rising in cycle n (IDLE) gives `o_grant` and `s_cyc_o` high in cycle n+1.
- **Release:** owner `cyc` low in cycle n gives IDLE in n+1. A waiting master is granted in n+1 and drives the slave from n+2, so there is one dead cycle between owners.
- **Response path:** ack and read data pass through combinationally with zero added latency.
- **Ack at the timeout cycle:** the ack wins. It is delivered, there is no err, and the counter clears.
- **Ack and `cyc` drop together:** the ack is delivered, then the FSM goes to IDLE.
- **`s_ack_i` in IDLE or ABORT:** ignored and never forwarded.
- **Back-to-back bursts:** a master holding `cyc` keeps ownership indefinitely. Fairness applies only at `cyc` boundaries.

## Structure

- Package `wb_arb_pkg` holds:
  - the state enum (IDLE, OWNED, ABORT);
  - the master index constants `M_SD` = 0 and `M_LDR` = 1;
  - the default timeout constant.
- Sub-module `wb_rr_grant` computes the next owner from the two requests and `last` (combinational, 2-requester round-robin).
- The FSM, timeout counter and muxes stay in the top module.

## Test plan

1. **Single requester:** m0 reads at 0x100 and the slave acks 3 cycles after `s_stb_o`. Expect `o_grant`=01 one cycle after `cyc`, `m0_ack_o` in the same cycle as `s_ack_i`, `m0_dat_o` = slave data, `m1_ack_o`=0 throughout.
2. **Simultaneous request after reset:** both masters raise `cyc` together. Expect m0 granted first; after m0 drops `cyc`, IDLE for one cycle, then m1 granted. The next tie goes to m0.
3. **Locked burst:** m1 issues 4 reads under one `cyc` while m0 requests. Expect m0 to stay ungranted until m1 drops `cyc`, and all 4 acks routed to m1.
4. **Timeout:** with `TIMEOUT_CYCLES`=8, the slave never acks m0. Expect `m0_err_o` and `o_timeout` high for one cycle exactly 8 cycles after `stb`, `s_cyc_o` low the next cycle, and a late `s_ack_i` not forwarded.
5. **Ack on the last timeout cycle:** the ack arrives in cycle 7 of 8. Expect `m0_ack_o`=1, `m0_err_o`=0, `o_timeout`=0.
6. **Reset mid-transfer:** pulse `reset_n` low while m1 is owner. Expect `s_cyc_o`, `o_grant` and all acks at 0 immediately. After release, m0 wins a tie.

Source files
------------

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_pkg : shared types and constants for the flash WB arbiter     |
// | Rev 1.0    : initial release                                         |
// +----------------------------------------------------------------------+
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic M_SD  = 1'b0;
    localparam logic M_LDR = 1'b1;

    localparam int c_timeout_default = 4096;

endpackage
`default_nettype wire

// File: rtl/wb_rr_grant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_rr_grant : two-requester round-robin owner selection              |
// | Rev 1.0     : initial release                                        |
// +----------------------------------------------------------------------+
module wb_rr_grant
    import wb_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_next_owner
);

    always_comb begin
        o_valid      = |i_req;
        o_next_owner = M_SD;
        case (i_req)
            2'b10:   o_next_owner = M_LDR;
            // On a tie the master that did not own the bus last time wins.
            2'b11:   o_next_owner = ~i_last;
            default: o_next_owner = M_SD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_flash_arbiter : two-master WB arbiter for the SPI flash slave,    |
// |                    cyc-locked round-robin grant with stall timeout   |
// | Rev 1.0          : initial release                                   |
// +----------------------------------------------------------------------+
module wb_flash_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_timeout_default,
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 reset_n,

    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,

    output logic [1:0]           o_grant,
    output logic                 o_timeout
);

    localparam int                 c_cnt_w   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYCLES - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_nxt;
    logic                 r_owner;
    logic                 w_owner_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;

    logic                 w_req_valid;
    logic                 w_req_owner;
    logic                 w_own_cyc;
    logic                 w_own_stb;
    logic                 w_own_we;
    logic [ADR_WIDTH-1:0] w_own_adr;
    logic [DAT_WIDTH-1:0] w_own_dat;
    logic                 w_timeout_hit;

    wb_rr_grant u_rr_grant (
        .i_req        ({m1_cyc_i, m0_cyc_i}),
        .i_last       (r_last),
        .o_valid      (w_req_valid),
        .o_next_owner (w_req_owner)
    );

    assign w_own_cyc = (r_owner == M_LDR) ? m1_cyc_i : m0_cyc_i;
    assign w_own_stb = (r_owner == M_LDR) ? m1_stb_i : m0_stb_i;
    assign w_own_we  = (r_owner == M_LDR) ? m1_we_i  : m0_we_i;
    assign w_own_adr = (r_owner == M_LDR) ? m1_adr_i : m0_adr_i;
    assign w_own_dat = (r_owner == M_LDR) ? m1_dat_i : m0_dat_i;

    // An ack arriving in the final stall cycle takes priority over the abort.
    assign w_timeout_hit = (r_state == OWNED) && w_own_cyc && w_own_stb &&
                           !s_ack_i && (r_cnt == c_cnt_max);

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= M_SD;
            r_last  <= M_LDR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_req_owner;
                    w_last_nxt  = w_req_owner;
                end
            end
            OWNED: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ABORT;
                end else if (w_own_stb && !s_ack_i) begin
                    w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_w'(1);
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_err_o  = 1'b0;
        o_grant   = 2'b00;
        o_timeout = 1'b0;
        case (r_state)
            OWNED: begin
                s_cyc_o   = w_own_cyc;
                s_stb_o   = w_own_stb;
                s_we_o    = w_own_we;
                s_adr_o   = w_own_adr;
                s_dat_o   = w_own_dat;
                m0_dat_o  = s_dat_i;
                m1_dat_o  = s_dat_i;
                m0_ack_o  = (r_owner == M_SD)  && s_ack_i;
                m1_ack_o  = (r_owner == M_LDR) && s_ack_i;
                m0_err_o  = (r_owner == M_SD)  && w_timeout_hit;
                m1_err_o  = (r_owner == M_LDR) && w_timeout_hit;
                o_timeout = w_timeout_hit;
                o_grant   = (r_owner == M_LDR) ? 2'b10 : 2'b01;
            end
            ABORT: begin
                o_grant   = (r_owner == M_LDR) ? 2'b10 : 2'b01;
            end
            default: begin
                o_grant   = 2'b00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_flash_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_flash_arbiter : directed and random checks of wb_flash_arbiter |
// | Rev 1.0             : initial release                                |
// +----------------------------------------------------------------------+
module tb_wb_flash_arbiter;

    localparam int TO = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk_i = 1'b0;
    logic          reset_n  = 1'b0;

    // Master-side drive, index 0 = SD core, 1 = loader.
    logic          rc [2];
    logic          rs [2];
    logic          rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];

    logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_ack_i = 1'b0;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, o_timeout;
    logic [1:0]    o_grant;

    assign m0_cyc_i = rc[0];
    assign m0_stb_i = rs[0];
    assign m0_we_i  = rw[0];
    assign m0_adr_i = ra[0];
    assign m0_dat_i = rd[0];
    assign m1_cyc_i = rc[1];
    assign m1_stb_i = rs[1];
    assign m1_we_i  = rw[1];
    assign m1_adr_i = ra[1];
    assign m1_dat_i = rd[1];

    wb_flash_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ADR_WIDTH      (AW),
        .DAT_WIDTH      (DW)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .reset_n   (reset_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_adr_i  (m0_adr_i),
        .m0_dat_i  (m0_dat_i),
        .m0_dat_o  (m0_dat_o),
        .m0_ack_o  (m0_ack_o),
        .m0_err_o  (m0_err_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_adr_i  (m1_adr_i),
        .m1_dat_i  (m1_dat_i),
        .m1_dat_o  (m1_dat_o),
        .m1_ack_o  (m1_ack_o),
        .m1_err_o  (m1_err_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: owner index (-1 = nobody), abort flag, consecutive stall count.
    int          mo_own   = -1;
    bit          mo_abort = 1'b0;
    int          mo_stall = 0;
    int          mo_last  = 1;
    logic [1:0]  e_grant, e_ack, e_err;
    logic        e_cyc, e_stb, e_hit;

    always @(negedge wb_clk_i) begin : p_model
        if (!reset_n) begin
            chk("reset_outputs",
                {o_grant, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, o_timeout}, '0);
            mo_own = -1; mo_abort = 1'b0; mo_stall = 0; mo_last = 1;
        end else begin
            e_grant = 2'b00; e_cyc = 1'b0; e_stb = 1'b0; e_ack = 2'b00; e_err = 2'b00; e_hit = 1'b0;
            if (mo_own >= 0) begin
                e_grant = 2'(1 << mo_own);
                if (!mo_abort) begin
                    e_cyc = rc[mo_own];
                    e_stb = rs[mo_own];
                    e_hit = rc[mo_own] && rs[mo_own] && !s_ack_i && (mo_stall == TO - 1);
                    e_ack[mo_own] = s_ack_i;
                    e_err[mo_own] = e_hit;
                end
            end
            chk("control(grant,cyc,stb,ack0,ack1,err0,err1,tmo)",
                {o_grant, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, o_timeout},
                {e_grant, e_cyc, e_stb, e_ack[0], e_ack[1], e_err[0], e_err[1], e_hit});
            if (mo_own >= 0 && !mo_abort)
                chk("datapath(we,adr,wdat,rdat0,rdat1)",
                    {s_we_o, s_adr_o, s_dat_o, m0_dat_o, m1_dat_o},
                    {rw[mo_own], ra[mo_own], rd[mo_own], s_dat_i, s_dat_i});

            if (mo_own < 0) begin
                if (rc[0] || rc[1]) begin
                    mo_own   = (rc[0] && rc[1]) ? 1 - mo_last : (rc[0] ? 0 : 1);
                    mo_last  = mo_own;
                    mo_stall = 0;
                end
            end else if (!rc[mo_own]) begin
                mo_own = -1; mo_abort = 1'b0; mo_stall = 0;
            end else if (!mo_abort) begin
                if (e_hit) mo_abort = 1'b1;
                else if (rs[mo_own] && !s_ack_i) mo_stall = (mo_stall < TO - 1) ? mo_stall + 1 : mo_stall;
                else mo_stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic new_xfer(input int i);
        rs[i] = 1'b1;
        rw[i] = 1'($urandom);
        ra[i] = $urandom;
        rd[i] = $urandom;
    endtask

    int   k;
    int   left [2];
    logic g_ack [2];
    logic g_err [2];
    int   ack_pct;

    initial begin : p_stim
        for (int i = 0; i < 2; i++) begin
            rc[i] = 1'b0; rs[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
            left[i] = 0; g_ack[i] = 1'b0; g_err[i] = 1'b0;
        end
        #2;
        chk("rst_grant", o_grant, 2'b00);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        repeat (3) @(posedge wb_clk_i);
        #1 reset_n = 1'b1;

        // Single read from m0, slave acks three cycles after stb.
        tick(); rc[0] = 1'b1; rs[0] = 1'b1; ra[0] = 32'h100; rw[0] = 1'b0;
        #2 chk("t1_idle_grant", o_grant, 2'b00);
        tick(); #2;
        chk("t1_grant", o_grant, 2'b01);
        chk("t1_s_cyc", s_cyc_o, 1'b1);
        chk("t1_s_adr", s_adr_o, 32'h100);
        tick(); tick(); tick();
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE0001;
        #2;
        chk("t1_ack", m0_ack_o, 1'b1);
        chk("t1_rdata", m0_dat_o, 32'hCAFE0001);
        chk("t1_m1_ack", m1_ack_o, 1'b0);
        tick(); s_ack_i = 1'b0; rc[0] = 1'b0; rs[0] = 1'b0;
        tick();

        // Stalled transfer must abort exactly TO cycles after stb.
        tick(); rc[0] = 1'b1; rs[0] = 1'b1; ra[0] = 32'h200;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(); #2;
            if (o_timeout) begin k = i; break; end
        end
        chk("t4_latency", k, 8);
        chk("t4_err", m0_err_o, 1'b1);
        tick(); s_ack_i = 1'b1; #2;
        chk("t4_s_cyc_after", s_cyc_o, 1'b0);
        chk("t4_late_ack", m0_ack_o, 1'b0);
        chk("t4_grant_hold", o_grant, 2'b01);
        tick(); s_ack_i = 1'b0; rc[0] = 1'b0; rs[0] = 1'b0;
        tick(); tick();

        // Ack in the would-be timeout cycle wins.
        tick(); rc[0] = 1'b1; rs[0] = 1'b1;
        repeat (8) tick();
        s_ack_i = 1'b1; #2;
        chk("t5_ack", m0_ack_o, 1'b1);
        chk("t5_err", m0_err_o, 1'b0);
        chk("t5_tmo", o_timeout, 1'b0);
        tick(); s_ack_i = 1'b0; #2;
        chk("t5_cnt_cleared", o_timeout, 1'b0);
        tick(); rc[0] = 1'b0; rs[0] = 1'b0;
        tick(); tick();

        // Asynchronous reset while m1 owns the bus, then tie arbitration.
        tick(); rc[1] = 1'b1; rs[1] = 1'b1; ra[1] = 32'h300;
        tick(); #2 chk("t6_m1_grant", o_grant, 2'b10);
        tick(); s_ack_i = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_s_cyc", s_cyc_o, 1'b0);
        chk("t6_rst_grant", o_grant, 2'b00);
        chk("t6_rst_acks", {m0_ack_o, m1_ack_o}, 2'b00);
        tick(); s_ack_i = 1'b0; reset_n = 1'b1; rc[0] = 1'b1; rs[0] = 1'b1;
        #2 chk("t6_release_idle", o_grant, 2'b00);
        tick(); #2 chk("t6_tie_m0", o_grant, 2'b01);
        rc[0] = 1'b0; rs[0] = 1'b0;
        tick(); #2 chk("t2_dead_cycle", o_grant, 2'b00);
        tick(); #2 chk("t2_m1_after", o_grant, 2'b10);
        rc[1] = 1'b0; rs[1] = 1'b0;
        tick(); rc[0] = 1'b1; rc[1] = 1'b1;
        tick(); #2 chk("t2_next_tie_m0", o_grant, 2'b01);
        rc[0] = 1'b0; rc[1] = 1'b0;
        tick(); tick();

        // Random masters and a slave alternating between responsive and sluggish.
        for (int n = 0; n < 3000; n++) begin
            @(negedge wb_clk_i);
            g_ack[0] = m0_ack_o; g_err[0] = m0_err_o;
            g_ack[1] = m1_ack_o; g_err[1] = m1_err_o;
            @(posedge wb_clk_i);
            #1;
            if (n == 1500) reset_n = 1'b0;
            if (n == 1502) reset_n = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (!rc[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        rc[i] = 1'b1;
                        left[i] = $urandom_range(1, 4);
                        new_xfer(i);
                    end
                end else begin
                    if (g_err[i]) begin
                        rc[i] = 1'b0; rs[i] = 1'b0;
                    end else if (g_ack[i]) begin
                        left[i]--;
                        if (left[i] <= 0) begin rc[i] = 1'b0; rs[i] = 1'b0; end
                        else if ($urandom_range(0, 2) == 0) rs[i] = 1'b0;
                        else new_xfer(i);
                    end else if (!rs[i]) begin
                        if ($urandom_range(0, 1) == 1) new_xfer(i);
                    end
                    if (rc[i] && $urandom_range(0, 60) == 0) begin rc[i] = 1'b0; rs[i] = 1'b0; end
                end
            end
            #1;
            ack_pct = ((n / 300) % 2 == 1) ? 3 : 40;
            s_ack_i = s_stb_o ? ($urandom_range(0, 99) < ack_pct) : ($urandom_range(0, 9) == 0);
            s_dat_i = $urandom;
        end

        tick();
        for (int i = 0; i < 2; i++) begin rc[i] = 1'b0; rs[i] = 1'b0; end
        s_ack_i = 1'b0;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
